// File: rtl/scr1_dmi_chain_ctrl.sv
// scr1_dmi_chain_ctrl: SysCLK-side DMI/DTMCS scan-chain registers and DMI request handshake
// Optional response timeout: define SCR1_DMI_CHAIN_TIMEOUT_EN
module scr1_dmi_chain_ctrl #(
  parameter int CH_ID_W     = 2,
  parameter int CH_ID_DTMCS = 1,
  parameter int CH_ID_DMI   = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dmi_ch_sel_core,
  input  logic [CH_ID_W-1:0] dmi_ch_id_core,
  input  logic               dmi_ch_capture_core,
  input  logic               dmi_ch_shift_core,
  input  logic               dmi_ch_update_core,
  input  logic               dmi_ch_tdi_core,
  output logic               dmi_ch_tdo_core,
  output logic               dmi_req,
  output logic               dmi_wr,
  output logic [6:0]         dmi_addr,
  output logic [31:0]        dmi_wdata,
  input  logic               dmi_req_ack,
  input  logic               dmi_resp,
  input  logic [31:0]        dmi_rdata,
  input  logic               dmi_resp_err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t      state;
  logic [40:0] sreg;
  logic [31:0] last_rdata;
  logic [1:0]  sticky, stat, op;
  logic        is_dmi, is_dtmcs, act, cap, upd, sft, busy, hard, resp_take;
`ifdef SCR1_DMI_CHAIN_TIMEOUT_EN
  logic [7:0]  cnt;
`endif
  assign is_dmi          = dmi_ch_id_core == CH_ID_W'(CH_ID_DMI);
  assign is_dtmcs        = dmi_ch_id_core == CH_ID_W'(CH_ID_DTMCS);
  assign act             = dmi_ch_sel_core & (is_dmi | is_dtmcs);
  assign cap             = act & dmi_ch_capture_core;
  assign upd             = act & dmi_ch_update_core & ~dmi_ch_capture_core;
  assign sft             = act & dmi_ch_shift_core & ~dmi_ch_capture_core & ~dmi_ch_update_core;
  assign busy            = state != IDLE;
  assign stat            = busy ? 2'd3 : sticky;
  assign op              = sreg[1:0];
  assign hard            = upd & is_dtmcs & sreg[17];
  // a response arriving together with the ack completes the transfer; a hard reset discards it
  assign resp_take       = dmi_resp & ~hard & ((state == RESP) | (state == REQ & dmi_req_ack));
  assign dmi_ch_tdo_core = (is_dmi | is_dtmcs) & sreg[0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      last_rdata <= '0;
      sticky     <= '0;
      dmi_req    <= 1'b0;
      dmi_wr     <= 1'b0;
      dmi_addr   <= '0;
      dmi_wdata  <= '0;
`ifdef SCR1_DMI_CHAIN_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      if (state == REQ && dmi_req_ack) begin
        dmi_req <= 1'b0;
        state   <= RESP;
      end
      if (resp_take) begin
        if (!dmi_wr) last_rdata <= dmi_rdata;
        if (dmi_resp_err) sticky <= sticky | 2'b10;
        state <= IDLE;
      end
`ifdef SCR1_DMI_CHAIN_TIMEOUT_EN
      cnt <= (state == IDLE || (state == REQ && dmi_req_ack)) ? '0 : cnt + 8'd1;
      if (busy && cnt == 8'(TIMEOUT - 1)) begin
        dmi_req <= 1'b0;
        sticky  <= sticky | 2'b10;
        state   <= IDLE;
      end
`endif
      if (cap) begin
        if (is_dmi) begin
          sreg <= {dmi_addr, last_rdata, stat};
          if (busy) sticky <= 2'd3;
        end else begin
          sreg[31:0] <= {17'b0, 3'd1, sticky, 6'd7, 4'd1};
        end
      end
      if (upd && is_dmi) begin
        if (busy) begin
          sticky <= 2'd3;
        end else if (sticky == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
          dmi_addr  <= sreg[40:34];
          dmi_wdata <= sreg[33:2];
          dmi_wr    <= op == 2'd2;
          dmi_req   <= 1'b1;
          state     <= REQ;
        end
      end
      if (upd && is_dtmcs && (sreg[16] || sreg[17])) sticky <= 2'd0;
      if (hard) begin
        dmi_req <= 1'b0;
        state   <= IDLE;
      end
      if (sft) begin
        if (is_dmi) sreg <= {dmi_ch_tdi_core, sreg[40:1]};
        else sreg[31:0] <= {dmi_ch_tdi_core, sreg[31:1]};
      end
    end
  end
endmodule

// File: tb/tb_scr1_dmi_chain_ctrl.sv
// tb_scr1_dmi_chain_ctrl: table-driven DMI transfers plus hand-written busy/reset/timeout sequences
module tb_scr1_dmi_chain_ctrl;
  logic        clk = 0, rst = 1, sel = 0, cap = 0, sft = 0, upd = 0, tdi = 0;
  logic        ack = 0, resp = 0, err = 0, tdo, req, wr;
  logic [1:0]  id = 0;
  logic [6:0]  addr;
  logic [31:0] wdata, rdata = 0;
  int          pass = 0, total = 0;
  logic [40:0] sb[$];
  typedef struct {
    logic [6:0]  a;
    logic [31:0] d;
    logic [1:0]  op;
    logic [31:0] rd;
    logic        e;
    logic        exp_req;
    logic [40:0] exp_cap;
  } vec_t;
  vec_t v[5];
  always #5 clk = ~clk;
  scr1_dmi_chain_ctrl dut (
    .clk(clk), .rst(rst), .dmi_ch_sel_core(sel), .dmi_ch_id_core(id),
    .dmi_ch_capture_core(cap), .dmi_ch_shift_core(sft), .dmi_ch_update_core(upd),
    .dmi_ch_tdi_core(tdi), .dmi_ch_tdo_core(tdo), .dmi_req(req), .dmi_wr(wr),
    .dmi_addr(addr), .dmi_wdata(wdata), .dmi_req_ack(ack), .dmi_resp(resp),
    .dmi_rdata(rdata), .dmi_resp_err(err)
  );
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask
  task automatic pulse(input logic c, input logic u, input logic s, input logic t);
    @(negedge clk);
    cap = c; upd = u; sft = s; tdi = t;
    @(negedge clk);
    cap = 0; upd = 0; sft = 0; tdi = 0;
  endtask
  task automatic scan(input string name, input logic [1:0] cid, input int n,
                      input logic [40:0] exp, input logic [40:0] payload, input logic do_upd);
    logic [40:0] got, e;
    got = '0;
    sel = 1; id = cid;
    sb.push_back(exp);
    pulse(1, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      got[i] = tdo;
      pulse(0, 0, 1, payload[i]);
    end
    e = sb.pop_front();
    chk(name, got, e);
    if (do_upd) pulse(0, 1, 0, 0);
  endtask
  task automatic dm_ack(input logic with_resp, input logic [31:0] rd, input logic e);
    @(negedge clk);
    ack = 1; resp = with_resp; rdata = rd; err = e;
    @(negedge clk);
    ack = 0; resp = 0; err = 0;
  endtask
  task automatic dm_resp(input logic [31:0] rd, input logic e);
    @(negedge clk);
    resp = 1; rdata = rd; err = e;
    @(negedge clk);
    resp = 0; err = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v[0] = '{7'h10, 32'hDEADBEEF, 2'd2, 32'h0,        1'b0, 1'b1, {7'h10, 32'h0,        2'd0}};
    v[1] = '{7'h11, 32'h0,        2'd1, 32'h12345678, 1'b0, 1'b1, {7'h11, 32'h12345678, 2'd0}};
    v[2] = '{7'h22, 32'h55,       2'd0, 32'h0,        1'b0, 1'b0, {7'h11, 32'h12345678, 2'd0}};
    v[3] = '{7'h05, 32'h0,        2'd1, 32'hAAAA5555, 1'b1, 1'b1, {7'h05, 32'hAAAA5555, 2'd2}};
    v[4] = '{7'h7F, 32'h1,        2'd2, 32'h0,        1'b0, 1'b0, {7'h05, 32'hAAAA5555, 2'd2}};
    repeat (3) @(negedge clk);
    chk("reset_req", {req, wr, addr, wdata}, 0);
    chk("reset_tdo", tdo, 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      scan("dmi_cap", 2'd2, 41, i == 0 ? 41'b0 : v[i-1].exp_cap, {v[i].a, v[i].d, v[i].op}, 1);
      chk("req_after_update", req, v[i].exp_req);
      if (v[i].exp_req) begin
        chk("req_fields", {wr, addr, wdata}, {v[i].op == 2'd2, v[i].a, v[i].d});
        dm_ack(0, 0, 0);
        chk("req_drop_on_ack", req, 0);
        dm_resp(v[i].rd, v[i].e);
      end
    end
    scan("dtmcs_err", 2'd1, 32, 41'h1871, 41'h10000, 1);
    scan("dtmcs_clr", 2'd1, 32, 41'h1071, 41'h0, 0);
    scan("busy_cap0", 2'd2, 41, {7'h05, 32'hAAAA5555, 2'd0}, {7'h11, 32'h0, 2'd1}, 1);
    chk("busy_req", req, 1);
    dm_ack(0, 0, 0);
    pulse(0, 1, 0, 0);
    chk("busy_noreq", req, 0);
    dm_resp(32'h0BADF00D, 0);
    scan("busy_stat3", 2'd2, 41, {7'h11, 32'h0BADF00D, 2'd3}, {7'h33, 32'h0, 2'd1}, 1);
    chk("sticky_drop", req, 0);
    scan("dtmcs_st3", 2'd1, 32, 41'h1C71, 41'h10000, 1);
    scan("busy_cap1", 2'd2, 41, {7'h11, 32'h0BADF00D, 2'd0}, {7'h44, 32'h0, 2'd1}, 1);
    chk("rd_accept", {req, addr}, {1'b1, 7'h44});
    dm_ack(1, 32'hCAFEF00D, 0);
    chk("ack_resp_idle", req, 0);
    scan("hard_cap", 2'd2, 41, {7'h44, 32'hCAFEF00D, 2'd0}, {7'h12, 32'h0, 2'd1}, 1);
    chk("hard_req_on", req, 1);
    scan("hard_dtmcs", 2'd1, 32, 41'h1071, 41'h20000, 1);
    chk("hard_req_off", req, 0);
    dm_resp(32'hFFFFFFFF, 1);
    scan("hard_after", 2'd2, 41, {7'h12, 32'hCAFEF00D, 2'd0}, {7'h01, 32'h0, 2'd1}, 1);
    chk("stall_req_on", req, 1);
    repeat (300) @(negedge clk);
`ifdef SCR1_DMI_CHAIN_TIMEOUT_EN
    chk("timeout_req", req, 0);
    scan("timeout_stat", 2'd2, 41, {7'h01, 32'hCAFEF00D, 2'd2}, 41'h0, 0);
    scan("timeout_dtmcs", 2'd1, 32, 41'h1871, 41'h10000, 1);
`else
    chk("stall_req_held", req, 1);
    scan("stall_dtmcs", 2'd1, 32, 41'h1071, 41'h20000, 1);
`endif
    chk("recovered_idle", req, 0);
    sel = 1; id = 2'd1;
    pulse(1, 0, 0, 0);
    id = 2'd0;
    #1 chk("tdo_unknown_id", tdo, 0);
    id = 2'd1;
    #1 chk("tdo_dtmcs_lsb", tdo, 1);
    sel = 0;
    pulse(0, 0, 1, 0);
    chk("shift_ignored_unsel", tdo, 1);
    scan("rst_cap", 2'd2, 41, {7'h01, 32'hCAFEF00D, 2'd0}, {7'h02, 32'h0, 2'd1}, 1);
    chk("rst_req_on", req, 1);
    @(negedge clk);
    #2 rst = 1;
    #1 chk("rst_req_async", req, 0);
    chk("rst_tdo", tdo, 0);
    @(negedge clk);
    rst = 0;
    scan("rst_dtmcs", 2'd1, 32, 41'h1071, 41'h0, 0);
    scan("rst_dmi", 2'd2, 41, 41'h0, 41'h0, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
